// File: rtl/bram_port_arbiter.sv
// Two-requester round-robin burst arbiter for the single 32-bit port of my_bram.
// Reads are tagged with their issuer and returned after the memory's 2-cycle latency.
module bram_port_arbiter #(
  parameter int BRAM_ADDR_WIDTH = 15,
  parameter int MAX_BURST       = 16
) (
  input  logic                       clk,
  input  logic                       rstn,

  input  logic                       r0_req,
  input  logic [BRAM_ADDR_WIDTH-1:0] r0_addr,
  input  logic [3:0]                 r0_we,
  input  logic [31:0]                r0_wrdata,
  input  logic                       r0_last,
  output logic                       r0_gnt,
  output logic                       r0_rvalid,

  input  logic                       r1_req,
  input  logic [BRAM_ADDR_WIDTH-1:0] r1_addr,
  input  logic [3:0]                 r1_we,
  input  logic [31:0]                r1_wrdata,
  input  logic                       r1_last,
  output logic                       r1_gnt,
  output logic                       r1_rvalid,

  output logic [31:0]                rddata,

  output logic [BRAM_ADDR_WIDTH-1:0] BRAM_ADDR,
  output logic [31:0]                BRAM_WRDATA,
  output logic [3:0]                 BRAM_WE,
  output logic                       BRAM_EN,
  output logic                       BRAM_RST,
  input  logic [31:0]                BRAM_RDDATA,

  output logic                       busy
);

  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BURST - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_e;

  typedef struct packed {
    logic valid;
    logic owner;
  } rd_tag_t;

  state_e           state_q, state_d;
  logic             rr_q, rr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  rd_tag_t          s0_q, s0_d, s1_q;

  logic                       granted;
  logic                       own_sel;
  logic                       own_req;
  logic                       own_last;
  logic                       other_req;
  logic [BRAM_ADDR_WIDTH-1:0] own_addr;
  logic [3:0]                 own_we;
  logic [31:0]                own_wrdata;
  logic                       beat;
  logic                       is_read;
  logic                       burst_end;
  logic                       grant_any;
  logic                       winner;

  assign granted = (state_q != IDLE);
  assign own_sel = (state_q == OWN1);

  // NOTE: every signal assigned in an always_comb gets a default first so no latch is inferred.
  always_comb begin
    own_req    = r0_req;
    own_last   = r0_last;
    other_req  = r1_req;
    own_addr   = r0_addr;
    own_we     = r0_we;
    own_wrdata = r0_wrdata;
    if (own_sel) begin
      own_req    = r1_req;
      own_last   = r1_last;
      other_req  = r0_req;
      own_addr   = r1_addr;
      own_we     = r1_we;
      own_wrdata = r1_wrdata;
    end
  end

  assign beat    = granted & own_req;
  assign is_read = beat & (own_we == 4'h0);

  // Dropping req while granted also closes the burst, just without a beat.
  assign burst_end = granted & (~own_req | own_last | (cnt_q == LAST_CNT));

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    cnt_d     = cnt_q;
    grant_any = 1'b0;
    winner    = rr_q;

    unique case (state_q)
      IDLE: begin
        if (r0_req | r1_req) begin
          grant_any = 1'b1;
          winner    = (r0_req & r1_req) ? rr_q : r1_req;
        end
      end
      default: begin
        if (burst_end) begin
          if (other_req) begin
            grant_any = 1'b1;
            winner    = ~own_sel;
          end else if (own_req) begin
            grant_any = 1'b1;
            winner    = own_sel;
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end else if (beat) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    endcase

    // The pointer always moves to the requester that did not just win.
    if (grant_any) begin
      state_d = winner ? OWN1 : OWN0;
      rr_d    = ~winner;
      cnt_d   = '0;
    end
  end

  always_comb begin
    s0_d       = '0;
    s0_d.valid = is_read;
    s0_d.owner = own_sel;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      rr_q    <= 1'b0;
      cnt_q   <= '0;
      s0_q    <= '0;
      s1_q    <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      s0_q    <= s0_d;
      s1_q    <= s0_q;
    end
  end

  assign r0_gnt    = (state_q == OWN0);
  assign r1_gnt    = (state_q == OWN1);
  assign r0_rvalid = s1_q.valid & ~s1_q.owner;
  assign r1_rvalid = s1_q.valid &  s1_q.owner;
  assign rddata    = BRAM_RDDATA;

  // Memory inputs are quiet outside beats; EN stays up one extra cycle to clock the read out.
  assign BRAM_ADDR   = beat ? own_addr   : '0;
  assign BRAM_WE     = beat ? own_we     : 4'h0;
  assign BRAM_WRDATA = beat ? own_wrdata : 32'h0;
  assign BRAM_EN     = beat | s0_q.valid;
  assign BRAM_RST    = ~rstn;

  assign busy = granted | s0_q.valid | s1_q.valid;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Bench for bram_port_arbiter: behavioural 2-cycle BRAM, requester tasks, read scoreboard and grant traces.
module tb_bram_port_arbiter;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req   [2];
  logic [14:0] addr  [2];
  logic [3:0]  we    [2];
  logic [31:0] wdata [2];
  logic        last  [2];
  logic        gnt   [2];
  logic        rvalid[2];
  logic [31:0] rddata;
  logic [14:0] BRAM_ADDR;
  logic [31:0] BRAM_WRDATA;
  logic [3:0]  BRAM_WE;
  logic        BRAM_EN;
  logic        BRAM_RST;
  logic [31:0] BRAM_RDDATA;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    logic        owner;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t       sb_q[$];
  logic [1:0] trace_q[$];
  logic [1:0] trace_exp[$];
  logic       trace_en = 1'b0;
  logic       preload;

  always #5 clk = ~clk;

  bram_port_arbiter #(.BRAM_ADDR_WIDTH(15), .MAX_BURST(4)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .r0_req     (req[0]),
    .r0_addr    (addr[0]),
    .r0_we      (we[0]),
    .r0_wrdata  (wdata[0]),
    .r0_last    (last[0]),
    .r0_gnt     (gnt[0]),
    .r0_rvalid  (rvalid[0]),
    .r1_req     (req[1]),
    .r1_addr    (addr[1]),
    .r1_we      (we[1]),
    .r1_wrdata  (wdata[1]),
    .r1_last    (last[1]),
    .r1_gnt     (gnt[1]),
    .r1_rvalid  (rvalid[1]),
    .rddata     (rddata),
    .BRAM_ADDR  (BRAM_ADDR),
    .BRAM_WRDATA(BRAM_WRDATA),
    .BRAM_WE    (BRAM_WE),
    .BRAM_EN    (BRAM_EN),
    .BRAM_RST   (BRAM_RST),
    .BRAM_RDDATA(BRAM_RDDATA),
    .busy       (busy)
  );

  // Memory model: address registered, then output register; both advance only while EN is high.
  logic [31:0] mem [0:8191];
  logic [31:0] rd_s1 = 32'h0;
  logic [31:0] rd_s2 = 32'h0;
  always @(posedge clk) begin
    if (preload) begin
      for (int k = 0; k < 8192; k++) mem[k] <= 32'hC000_0000 + 32'(k);
      mem[48] <= 32'h1122_3344;
    end else if (BRAM_EN) begin
      rd_s1 <= mem[BRAM_ADDR[14:2]];
      rd_s2 <= rd_s1;
      for (int b = 0; b < 4; b++)
        if (BRAM_WE[b]) mem[BRAM_ADDR[14:2]][8*b +: 8] <= BRAM_WRDATA[8*b +: 8];
    end
  end
  assign BRAM_RDDATA = rd_s2;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Scoreboard monitor: every rvalid pops one expected {owner, data, cycle}.
  always @(negedge clk) begin
    if (rvalid[0] || rvalid[1]) begin
      exp_t e;
      check("rvalid_exclusive", 32'(rvalid[0] & rvalid[1]), 32'd0);
      if (sb_q.size() == 0) begin
        check("unexpected_rvalid", 32'(rvalid[1]) + 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("rd_owner", 32'(rvalid[1]), 32'(e.owner));
        check("rd_data",  rddata,         e.data);
        check("rd_cycle", 32'(cyc),       32'(e.cyc));
      end
    end
    if (!((req[0] & gnt[0]) | (req[1] & gnt[1])))
      check("we_nonbeat", 32'(BRAM_WE), 32'd0);
    if (trace_en) trace_q.push_back({gnt[1], gnt[0]});
  end

  // One burst from requester r; reads expect d0+i, writes store d0+i.
  task automatic run_burst(input int r, input int n, input logic [14:0] base,
                           input logic [3:0] wen, input logic [31:0] d0, input bit use_last);
    for (int i = 0; i < n; i++) begin
      int waited;
      waited   = 0;
      req[r]   = 1'b1;
      addr[r]  = base + 15'(4 * i);
      we[r]    = wen;
      wdata[r] = (wen != 4'h0) ? d0 + 32'(i) : 32'h0;
      last[r]  = use_last && (i == n - 1);
      @(negedge clk);
      while (!gnt[r]) begin
        waited++;
        if (waited > 100) begin
          check("gnt_timeout", 32'(waited), 32'd0);
          req[r]  = 1'b0;
          last[r] = 1'b0;
          return;
        end
        @(negedge clk);
      end
      if (wen == 4'h0) sb_q.push_back('{1'(r), d0 + 32'(i), cyc + 2});
      @(posedge clk);
      #1;
    end
    req[r]  = 1'b0;
    last[r] = 1'b0;
    we[r]   = 4'h0;
  endtask

  task automatic check_trace(input string name);
    for (int i = 0; i < trace_exp.size(); i++)
      check($sformatf("%s[%0d]", name, i),
            (i < trace_q.size()) ? 32'(trace_q[i]) : 32'hFFFF_FFFF, 32'(trace_exp[i]));
    trace_en = 1'b0;
    trace_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn    = 1'b0;
    preload = 1'b1;
    for (int r = 0; r < 2; r++) begin
      req[r] = 1'b0; addr[r] = '0; we[r] = '0; wdata[r] = '0; last[r] = 1'b0;
    end
    step(2);
    preload = 1'b0;

    check("rst_r0_gnt",    32'(gnt[0]),      32'd0);
    check("rst_r1_gnt",    32'(gnt[1]),      32'd0);
    check("rst_rvalid",    32'({rvalid[1], rvalid[0]}), 32'd0);
    check("rst_busy",      32'(busy),        32'd0);
    check("rst_en",        32'(BRAM_EN),     32'd0);
    check("rst_we",        32'(BRAM_WE),     32'd0);
    check("rst_addr",      32'(BRAM_ADDR),   32'd0);
    check("rst_wrdata",    BRAM_WRDATA,      32'd0);
    check("rst_bram_rst",  32'(BRAM_RST),    32'd1);
    rstn = 1'b1;
    #1;
    check("run_bram_rst",  32'(BRAM_RST),    32'd0);
    step(1);

    // Contention right after reset: r0 first, r1 follows with no idle cycle.
    trace_en = 1'b1;
    fork
      run_burst(0, 2, 15'h100, 4'hF, 32'h0000_00B0, 1'b1);
      run_burst(1, 2, 15'h200, 4'hF, 32'h0000_00B2, 1'b1);
    join
    step(3);
    trace_exp = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd0};
    check_trace("contention_trace");

    // Pointer now favours r0.
    trace_en = 1'b1;
    fork
      run_burst(0, 1, 15'h010, 4'h0, 32'hC000_0004, 1'b1);
      run_burst(1, 1, 15'h020, 4'h0, 32'hC000_0008, 1'b1);
    join
    step(3);
    trace_exp = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd0};
    check_trace("favour_r0_trace");

    // Single requester: 4 writes then readback A0..A3.
    run_burst(0, 4, 15'h000, 4'hF, 32'h0000_00A0, 1'b1);
    run_burst(0, 4, 15'h000, 4'h0, 32'h0000_00A0, 1'b1);
    step(4);
    check("single_busy_done", 32'(busy), 32'd0);

    // Interleaved reads: r0 at t, r1 at t+1.
    trace_en = 1'b1;
    fork
      run_burst(0, 1, 15'h010, 4'h0, 32'hC000_0004, 1'b1);
      begin
        step(1);
        run_burst(1, 1, 15'h020, 4'h0, 32'hC000_0008, 1'b1);
      end
    join
    step(3);
    trace_exp = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd0};
    check_trace("interleave_trace");

    // MAX_BURST=4: r1 streams 10 reads, r0 waits and preempts after beat 4.
    trace_en = 1'b1;
    fork
      run_burst(1, 10, 15'h400, 4'h0, 32'hC000_0100, 1'b0);
      begin
        step(2);
        run_burst(0, 2, 15'h800, 4'h0, 32'hC000_0200, 1'b1);
      end
    join
    step(3);
    trace_exp = '{2'd0, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1, 2'd1,
                  2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd0};
    check_trace("preempt_trace");

    // Partial write of byte 1, then read-after-write on the next beat.
    run_burst(1, 1, 15'h0C0, 4'b0010, 32'h0000_5500, 1'b1);
    run_burst(1, 1, 15'h0C0, 4'h0,    32'h1122_5544, 1'b1);
    step(4);

    // Reset with a read in stage 0: nothing may come back.
    req[0] = 1'b1; addr[0] = 15'h010; we[0] = 4'h0; last[0] = 1'b0;
    step(2);
    #2;
    rstn = 1'b0;
    #1;
    check("midrst_gnt", 32'(gnt[0]),  32'd0);
    check("midrst_en",  32'(BRAM_EN), 32'd0);
    check("midrst_busy", 32'(busy),   32'd0);
    req[0] = 1'b0;
    step(3);
    rstn = 1'b1;
    step(1);

    // After release r0 wins; memory contents survive the reset.
    trace_en = 1'b1;
    fork
      run_burst(0, 1, 15'h010, 4'h0, 32'hC000_0004, 1'b1);
      run_burst(1, 1, 15'h020, 4'h0, 32'hC000_0008, 1'b1);
    join
    step(3);
    trace_exp = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd0};
    check_trace("post_reset_trace");

    step(4);
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    check("final_busy", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
